// File: rtl/srt_div_pkg.sv
// Shared types and widths for the SRT divider scheduler slice.
package srt_div_pkg;

  localparam int FP32_W = 32;
  localparam int MANT_W = 24;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } sched_state_t;

  typedef enum logic [1:0] {
    ST_OK = 2'b00,
    ST_DZ = 2'b01,
    ST_TO = 2'b10
  } rsp_status_t;

endpackage

// File: rtl/srt_div_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester after last_grant,
// searched cyclically upward, wins.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx
);

  // Scan N_REQ positions starting just after the previous winner and keep the first hit.
  always_comb begin : scan
    logic [ID_W-1:0] idx;
    logic            found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = ID_W'((int'(last_grant) + i) % N_REQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/srt_div_sched.sv
// Round-robin scheduler sharing one iterative FP32 SRT divider core among
// several requesters, with divide-by-zero bypass and a completion watchdog.
module srt_div_sched
  import srt_div_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 32,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_REQ-1:0]               req_valid,
  output logic [N_REQ-1:0]               req_ready,
  input  logic [N_REQ-1:0][FP32_W-1:0]   req_dividend,
  input  logic [N_REQ-1:0][FP32_W-1:0]   req_divisor,
  output logic                           core_start,
  output logic [FP32_W-1:0]              core_dividend,
  output logic [FP32_W-1:0]              core_divisor,
  input  logic                           core_done,
  input  logic [MANT_W-1:0]              core_result,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_W-1:0]                rsp_id,
  output logic [MANT_W-1:0]              rsp_result,
  output logic [1:0]                     rsp_status
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  sched_state_t      state_q, state_d;
  logic [ID_W-1:0]   last_grant_q;
  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_idx;
  logic              any_req;
  logic              div_zero;
  logic              timeout_hit;
  logic [CNT_W-1:0]  cnt_q;
  logic [FP32_W-1:0] dividend_q, divisor_q;
  logic [ID_W-1:0]   id_q;
  logic [MANT_W-1:0] result_q;
  rsp_status_t       status_q;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign any_req     = |req_valid;
  assign div_zero    = (req_divisor[grant_idx][FP32_W-2:0] == '0);
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Accept is only offered in IDLE and is suppressed while reset is held.
  assign req_ready     = (state_q == IDLE && rst) ? grant : '0;
  assign core_start    = (state_q == ISSUE);
  assign rsp_valid     = (state_q == RESP);
  assign core_dividend = dividend_q;
  assign core_divisor  = divisor_q;
  assign rsp_id        = id_q;
  assign rsp_result    = result_q;
  assign rsp_status    = status_q;

  // State register, cleared asynchronously so an in-flight operation is abandoned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; done takes priority over the watchdog in WAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = div_zero ? RESP : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (core_done || timeout_hit) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand/response registers, arbitration pointer and watchdog counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= ID_W'(N_REQ - 1);
      dividend_q   <= '0;
      divisor_q    <= '0;
      id_q         <= '0;
      result_q     <= '0;
      status_q     <= ST_OK;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            dividend_q   <= req_dividend[grant_idx];
            divisor_q    <= req_divisor[grant_idx];
            id_q         <= grant_idx;
            last_grant_q <= grant_idx;
            if (div_zero) begin
              result_q <= '0;
              status_q <= ST_DZ;
            end
          end
        end
        ISSUE: cnt_q <= '0;
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (core_done) begin
            result_q <= core_result;
            status_q <= ST_OK;
          end else if (timeout_hit) begin
            result_q <= '0;
            status_q <= ST_TO;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_srt_div_sched.sv
// Directed scoreboard bench for srt_div_sched with a small latency-programmable core model.
module tb_srt_div_sched;

  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 32;
  localparam int ID_W    = 2;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [23:0]     result;
    logic [1:0]      status;
    int              t_acc;
    int              lat;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N_REQ-1:0]       req_valid = '0;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0][31:0] req_dividend = '0;
  logic [N_REQ-1:0][31:0] req_divisor = '0;
  logic                   core_start;
  logic [31:0]            core_dividend, core_divisor;
  logic                   core_done;
  logic [23:0]            core_result;
  logic                   rsp_valid;
  logic                   rsp_ready = 1'b1;
  logic [ID_W-1:0]        rsp_id;
  logic [23:0]            rsp_result;
  logic [1:0]             rsp_status;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  int          ccnt = 0;
  int          starts = 0;
  bit          core_en = 1'b0;
  bit          core_force = 1'b0;
  int          core_k = 0;
  logic [23:0] core_val = 24'hC00000;

  srt_div_sched #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT), .ID_W(ID_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .core_start    (core_start),
    .core_dividend (core_dividend),
    .core_divisor  (core_divisor),
    .core_done     (core_done),
    .core_result   (core_result),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_result    (rsp_result),
    .rsp_status    (rsp_status)
  );

  always #5 clk = ~clk;

  // Core model: done pulses k cycles into WAIT, i.e. k+1 cycles after the start pulse.
  always @(posedge clk) begin
    if (core_start) ccnt <= 1;
    else if (ccnt > 0) ccnt <= ccnt + 1;
    if (core_start) starts <= starts + 1;
  end

  assign core_done   = core_force || (core_en && ccnt == core_k + 1);
  assign core_result = core_val;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    check("rst_outputs", {req_ready, core_start, rsp_valid, rsp_id, rsp_result, rsp_status}, '0);
    check("rst_core_ops", {core_dividend, core_divisor}, '0);
    req_valid = '0;
    tick();
    rst = 1'b1;
  endtask

  // Drives a request mask with shared operands, checks the grant, and records the expected response.
  task automatic apply_stimulus(input logic [N_REQ-1:0] mask, input int idx,
                                input logic [31:0] dd, input logic [31:0] dv,
                                input logic [23:0] res, input logic [1:0] st, input int lat);
    logic [N_REQ-1:0] one_hot;
    exp_t e;
    one_hot = N_REQ'(1) << idx;
    for (int i = 0; i < N_REQ; i++) begin
      req_dividend[i] = dd;
      req_divisor[i]  = dv;
    end
    req_valid = mask;
    @(negedge clk);
    check("accept_grant", req_ready, one_hot);
    e.id = ID_W'(idx); e.result = res; e.status = st; e.t_acc = cyc; e.lat = lat;
    sb.push_back(e);
    tick();
    req_valid = '0;
  endtask

  task automatic wait_rsp(input int budget);
    int i;
    i = 0;
    while (!rsp_valid && i < budget) begin
      tick();
      @(negedge clk);
      i++;
    end
    if (!rsp_valid) begin
      n_vec++;
      n_err++;
      $error("[TB] FAIL rsp_wait observed=no_rsp_valid expected=rsp_valid_within_%0d", budget);
    end
  endtask

  task automatic check_output();
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $error("[TB] FAIL rsp_unexpected observed=rsp_id_%0d expected=no_response", rsp_id);
      return;
    end
    e = sb.pop_front();
    check("rsp_valid", rsp_valid, 1'b1);
    check("rsp_id", rsp_id, e.id);
    check("rsp_result", rsp_result, e.result);
    check("rsp_status", rsp_status, e.status);
    check("rsp_latency", cyc - e.t_acc, e.lat);
  endtask

  initial begin
    int order[5] = '{0, 1, 2, 3, 0};
    int n_grants;
    int last_acc;
    int starts_before;

    #2;
    $display("[TB] reset and single request");
    do_reset();
    core_en = 1'b1; core_k = 12; core_val = 24'hC00000;
    apply_stimulus(4'b0001, 0, 32'h40400000, 32'h3F800000, 24'hC00000, 2'b00, 15);
    @(negedge clk);
    check("issue_start", core_start, 1'b1);
    check("issue_operands", {core_dividend, core_divisor}, {32'h40400000, 32'h3F800000});
    tick();
    @(negedge clk);
    check("start_one_cycle", core_start, 1'b0);
    wait_rsp(40);
    check_output();
    tick();

    $display("[TB] fairness");
    do_reset();
    core_k = 0; core_val = 24'h123456;
    for (int i = 0; i < N_REQ; i++) begin
      req_dividend[i] = 32'h3F800000 + i;
      req_divisor[i]  = 32'h40000000;
    end
    req_valid = '1;
    n_grants = 0;
    last_acc = -1;
    for (int c = 0; c < 60 && n_grants < 5; c++) begin
      exp_t e;
      @(negedge clk);
      if (rsp_valid) check_output();
      if (req_ready != '0) begin
        check($sformatf("fair_grant%0d", n_grants), req_ready, N_REQ'(1) << order[n_grants]);
        e.id = ID_W'(order[n_grants]); e.result = 24'h123456; e.status = 2'b00;
        e.t_acc = cyc; e.lat = 3;
        sb.push_back(e);
        if (last_acc >= 0) check("fair_period", cyc - last_acc, 4);
        last_acc = cyc;
        n_grants++;
      end
      tick();
    end
    req_valid = '0;
    if (n_grants < 5) begin
      n_vec++;
      n_err++;
      $error("[TB] FAIL fair_grants observed=%0d expected=5", n_grants);
    end
    @(negedge clk);
    wait_rsp(20);
    check_output();
    tick();

    $display("[TB] divide by zero");
    starts_before = starts;
    core_val = 24'hABCDEF;
    apply_stimulus(4'b0100, 2, 32'h40000000, 32'h80000000, 24'h0, 2'b01, 1);
    @(negedge clk);
    check_output();
    tick();
    tick();
    @(negedge clk);
    check("dz_no_start", starts, starts_before);
    tick();

    $display("[TB] timeout then next request");
    core_en = 1'b0;
    apply_stimulus(4'b0010, 1, 32'h41200000, 32'h40A00000, 24'h0, 2'b10, 34);
    @(negedge clk);
    wait_rsp(60);
    check_output();
    tick();
    core_en = 1'b1; core_k = 3; core_val = 24'h800001;
    apply_stimulus(4'b1000, 3, 32'h41200000, 32'h40A00000, 24'h800001, 2'b00, 6);
    @(negedge clk);
    wait_rsp(20);
    check_output();
    tick();

    $display("[TB] response backpressure");
    core_k = 2; core_val = 24'hD55555; rsp_ready = 1'b0;
    apply_stimulus(4'b0001, 0, 32'h3F800000, 32'h40400000, 24'hD55555, 2'b00, 5);
    @(negedge clk);
    wait_rsp(20);
    check_output();
    req_valid = '1;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check($sformatf("bp_hold%0d", i), {rsp_valid, rsp_id, rsp_result, rsp_status, req_ready},
            {1'b1, 2'd0, 24'hD55555, 2'b00, 4'b0000});
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    check("bp_single_rsp", rsp_valid, 1'b0);
    tick();

    $display("[TB] reset during WAIT");
    core_en = 1'b0;
    apply_stimulus(4'b0100, 2, 32'h40490FDB, 32'h402DF854, 24'h0, 2'b00, 3);
    tick();
    tick();
    core_force = 1'b1;
    req_valid  = '1;
    rst        = 1'b0;
    #2;
    check("midrst_outputs", {req_ready, core_start, rsp_valid, rsp_id, rsp_result, rsp_status}, '0);
    check("midrst_core_ops", {core_dividend, core_divisor}, '0);
    sb.delete();
    tick();
    tick();
    req_valid = '0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("midrst_no_rsp%0d", i), rsp_valid, 1'b0);
      tick();
    end
    core_val = 24'hE00000;
    apply_stimulus(4'b1111, 0, 32'h40E00000, 32'h3F000000, 24'hE00000, 2'b00, 3);
    @(negedge clk);
    check("stale_done_issue", core_start, 1'b1);
    wait_rsp(20);
    check_output();
    tick();
    core_force = 1'b0;

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
